csa_accumulator: RTL
====================

Name: csa_accumulator

Overview:
- Sequential carry-save accumulator sitting directly downstream of the partial-product generator in the parameterized multiplier.
- Accepts one pre-shifted partial-product row per cycle and compresses it into redundant sum/carry registers using a 3:2 row.
- After the last row, it resolves sum+carry with a chunked carry-propagate adder over several cycles.
- It then presents the final product on a valid/ready output.

Parameters:
- W, 12, product/row width in bits (2N for an N×N multiply).
- K, 4, carry-propagate chunk width resolved per cycle; 1 ≤ K ≤ W.
- NCH, ceil(W/K) (localparam, not overridable), number of resolve cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pp_valid  in  1  partial-product row valid.
- pp_ready  out  1  accumulator can accept a row.
- pp_data  in  W  partial-product row, already shifted to its weight.
- pp_last  in  1  marks final row of the current operation; qualified by pp_valid.
- prod_valid  out  1  product available.
- prod_ready  in  1  consumer accepts product.
- prod_data  out  W  final product, modulo 2^W.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (async assert, sync release): state=ACCUM, S=0, C=0, chunk index=0, chunk carry=0, result=0. Outputs: pp_ready=1, prod_valid=0, prod_data=0.
- States: ACCUM, RESOLVE, OUT.
- ACCUM:
  - pp_ready=1.
  - Row accepted when pp_valid&pp_ready.
  - On accept: S<=S^C^pp_data; C<=((S&C)|(S&pp_data)|(C&pp_data))<<1, truncated to W; bit W-1 of the majority is discarded.
  - pp_last on an accepted row moves to RESOLVE next cycle, with chunk index=0 and carry=0.
  - pp_valid low: hold. pp_last without pp_valid is ignored.
- RESOLVE:
  - pp_ready=0.
  - Each cycle j (0..NCH-1): result[jK +: K] <= S[jK +: K]+C[jK +: K]+carry. Carry-out of the chunk is registered into carry.
  - Last chunk may be narrower than K when W%K≠0; only W bits are written.
  - After chunk NCH-1, go to OUT. The final carry-out is dropped.
- OUT:
  - prod_valid=1 and prod_data=result, both stable until prod_ready=1.
  - On handshake: S, C, result cleared; return to ACCUM with pp_ready=1 in the next cycle.
  - pp_ready=0 throughout OUT.
- Latency: last row accepted in cycle t → prod_valid first high in cycle t+1+NCH.
  - Minimum: 1 accept + NCH resolve + 1 handshake.
  - No overlap between operations.
- Single-row operation (pp_last on the first row): product equals that row.
- Zero rows: impossible. An operation always contains at least one row flagged pp_last.
- Reset mid-operation (any state): immediate return to reset values. A partial accumulation is lost and no product is emitted.
- Arithmetic is modulo 2^W throughout. For a true N×N multiply with W=2N no overflow occurs.

Optional Feature:
- Macro: CSA_ACC_OVF_DET_EN.
- When defined:
  - Extra output port prod_ovf (out, 1), valid with prod_valid, reset 0.
  - prod_ovf is a sticky OR of every discarded C majority bit during ACCUM and the final RESOLVE carry-out.
  - It clears on the product handshake.
- When undefined:
  - No port and no logic.
  - Discarded bits are silently dropped.

Decomposition:
- Package csa_acc_pkg: state enum (ACCUM, RESOLVE, OUT) and the ceil-division function used for NCH.
- One natural sub-module: csa_3to2_row, a parameterized W-bit combinational 3:2 compressor returning sum and unshifted majority vectors.
- The shift/truncate and state logic stay in csa_accumulator.

Test Plan:
- Full multiply: W=12, K=4; rows 63<<i for i=0..5, row 5 with pp_last, pp_valid every cycle, prod_ready=1 → prod_data=0xF81 (3969); prod_valid rises 4 cycles after the last accept.
- Single row: 0xABC with pp_last, prod_ready=1 → prod_data=0xABC after 1+3 cycles; pp_ready=0 during RESOLVE/OUT, then back to 1.
- Backpressure: 5×9 as rows 0x005 and 0x028 (last), with prod_ready held low 6 cycles → prod_data=0x02D held stable with prod_valid=1; pp_valid asserted meanwhile is not accepted; handshake then returns to ACCUM.
- Gapped input: rows 0x111, 0x222, 0x444 (last) with 2 idle pp_valid cycles between them → prod_data=0x777; S/C hold during the gaps.
- Non-divisible chunking: W=10, K=4 (NCH=3), rows 0x3FF and 0x001 (last) → prod_data=0x000 after 3 resolve cycles; with CSA_ACC_OVF_DET_EN, prod_ovf=1.
- Reset mid-RESOLVE: deassert rst_n during chunk 1 → all outputs at reset values immediately; the next operation (row 0x00F, last) yields exactly 0x00F.

Source files
------------

// File: rtl/csa_acc_pkg.sv
// Shared types and helpers for the carry-save accumulator.
// Holds the controller state encoding and the ceil-division used to size the resolve phase.
package csa_acc_pkg;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      RESOLVE = 2'd1,
      OUT     = 2'd2
   } state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/csa_3to2_row.sv
// W-bit combinational 3:2 compressor row: bitwise sum and unshifted majority.
// The caller owns the weight shift of the majority vector.
module csa_3to2_row #(
   parameter int W = 12
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] maj
);

   assign sum = a ^ b ^ c;
   assign maj = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: compresses shifted partial-product rows, resolves sum+carry K bits per cycle.
// Optional overflow flag on the product output is enabled with macro CSA_ACC_OVF_DET_EN.
module csa_accumulator
   import csa_acc_pkg::*;
#(
   parameter int W = 12,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pp_valid,
   output logic         pp_ready,
   input  logic [W-1:0] pp_data,
   input  logic         pp_last,
   output logic         prod_valid,
   input  logic         prod_ready,
   output logic [W-1:0] prod_data
`ifdef CSA_ACC_OVF_DET_EN
   ,
   output logic         prod_ovf
`endif
);

   localparam int NCH = ceil_div(W, K);
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int WL  = W - (NCH - 1) * K;
   localparam int KP  = K + 1;

   state_t        state_q, state_d;
   logic [W-1:0]  s_q, c_q, result_q;
   logic [IW-1:0] idx_q;
   logic          cy_q;

   logic [W-1:0]  row_sum, row_maj;
   logic          last_chunk;
   int            sh;
   logic [K-1:0]  s_chunk, c_chunk;
   logic [K:0]    chunk_sum;
   logic          chunk_cout;
   logic [W-1:0]  chunk_mask, chunk_val, result_next;

   csa_3to2_row #(.W(W)) u_row (
      .a   (s_q),
      .b   (c_q),
      .c   (pp_data),
      .sum (row_sum),
      .maj (row_maj)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ACCUM;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      pp_ready   = 1'b0;
      prod_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            pp_ready = 1'b1;
            if (pp_valid && pp_last) state_d = RESOLVE;
         end
         RESOLVE: if (last_chunk) state_d = OUT;
         OUT: begin
            prod_valid = 1'b1;
            if (prod_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   // A narrow final chunk has zero padding above bit WL, so its carry-out lands at bit WL.
   always_comb begin
      last_chunk  = (idx_q == IW'(NCH - 1));
      sh          = int'(idx_q) * K;
      s_chunk     = K'(s_q >> sh);
      c_chunk     = K'(c_q >> sh);
      chunk_sum   = {1'b0, s_chunk} + {1'b0, c_chunk} + KP'(cy_q);
      chunk_cout  = last_chunk ? chunk_sum[WL] : chunk_sum[K];
      chunk_mask  = W'({K{1'b1}}) << sh;
      chunk_val   = W'(chunk_sum[K-1:0]) << sh;
      result_next = (result_q & ~chunk_mask) | chunk_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q      <= '0;
         c_q      <= '0;
         result_q <= '0;
         idx_q    <= '0;
         cy_q     <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: if (pp_valid) begin
               s_q <= row_sum;
               c_q <= row_maj << 1;
               if (pp_last) begin
                  idx_q <= '0;
                  cy_q  <= 1'b0;
               end
            end
            RESOLVE: begin
               result_q <= result_next;
               cy_q     <= last_chunk ? 1'b0 : chunk_cout;
               idx_q    <= last_chunk ? '0 : idx_q + IW'(1);
            end
            OUT: if (prod_ready) begin
               s_q      <= '0;
               c_q      <= '0;
               result_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign prod_data = result_q;

`ifdef CSA_ACC_OVF_DET_EN
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM:   if (pp_valid) ovf_q <= ovf_q | row_maj[W-1];
            RESOLVE: if (last_chunk) ovf_q <= ovf_q | chunk_cout;
            OUT:     if (prod_ready) ovf_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign prod_ovf = ovf_q;
`endif

endmodule
